// File: rtl/fe_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the FE latch for decode, handling decode stalls, AGEX redirects and sticky halt.
module fe_fetch_stage #(
  parameter int                    DBITS          = 32,
  parameter int                    INSTBITS       = 32,
  parameter logic [DBITS-1:0]      STARTPC        = '0,
  parameter int                    IMEM_ADDRBITS  = 14,
  parameter logic [INSTBITS-1:0]   HALT_INST      = 32'h0000_0073,
  parameter int                    FE_LATCH_WIDTH = 1 + INSTBITS + 3 * DBITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      from_DE_to_FE,
  input  logic [DBITS:0]            from_AGEX_to_FE,
  output logic [IMEM_ADDRBITS-1:0]  imem_addr,
  input  logic [INSTBITS-1:0]       imem_rdata,
  output logic [FE_LATCH_WIDTH-1:0] FE_latch_out,
  output logic                      halted
);

  logic             stall_DE;
  logic             br_redirect;
  logic [DBITS-1:0] br_target;
  logic [DBITS-1:0] br_target_aligned;
  logic [DBITS-1:0] PC_FE;
  logic [DBITS-1:0] pcplus_FE;
  logic [DBITS-1:0] inst_count_FE;
  logic             fetch_ok;

  assign stall_DE    = from_DE_to_FE;
  assign br_redirect = from_AGEX_to_FE[DBITS];
  assign br_target   = from_AGEX_to_FE[DBITS-1:0];

  // Targets are word-aligned by construction; drop any stray low bits.
  assign br_target_aligned = br_target & ~DBITS'(3);

  assign pcplus_FE = PC_FE + DBITS'(4);
  assign imem_addr = PC_FE[IMEM_ADDRBITS+1:2];
  assign fetch_ok  = !halted && !stall_DE && !br_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_FE         <= STARTPC;
      inst_count_FE <= '0;
      FE_latch_out  <= '0;
      halted        <= 1'b0;
    end else if (br_redirect) begin
      PC_FE        <= br_target_aligned;
      FE_latch_out <= '0;
      halted       <= 1'b0;
    end else if (stall_DE) begin
      PC_FE         <= PC_FE;
      inst_count_FE <= inst_count_FE;
      FE_latch_out  <= FE_latch_out;
    end else if (halted) begin
      FE_latch_out <= '0;
    end else if (fetch_ok) begin
      FE_latch_out  <= {1'b1, imem_rdata, PC_FE, pcplus_FE, inst_count_FE};
      PC_FE         <= pcplus_FE;
      inst_count_FE <= inst_count_FE + DBITS'(1);
      if (imem_rdata == HALT_INST) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fe_fetch_stage.sv
// Self-checking bench for fe_fetch_stage: directed scenarios followed by a random
// stall/redirect/reset mix, compared against a transaction-level fetch model.
module tb_fe_fetch_stage;

  localparam int          LW    = 129;
  localparam logic [31:0] HALT  = 32'h0000_0073;
  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam int          WORDS = 16384;

  logic          clk = 1'b0;
  logic          reset;
  logic          from_DE_to_FE;
  logic [32:0]   from_AGEX_to_FE;
  logic [13:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic [LW-1:0] FE_latch_out;
  logic          halted;

  logic [31:0]   mem [0:WORDS-1];

  int unsigned   n_cmp  = 0;
  int unsigned   n_fail = 0;

  // Reference model state
  logic [31:0]   m_pc;
  logic [31:0]   m_cnt;
  logic          m_halted;
  logic [LW-1:0] m_latch;

  fe_fetch_stage #(
    .DBITS         (32),
    .INSTBITS      (32),
    .STARTPC       (32'h0000_0000),
    .IMEM_ADDRBITS (14),
    .HALT_INST     (HALT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_to_FE   (from_DE_to_FE),
    .from_AGEX_to_FE (from_AGEX_to_FE),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .FE_latch_out    (FE_latch_out),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the architectural fetch behaviour.
  task automatic model_edge(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
    logic [31:0] inst;
    if (rst) begin
      m_pc = 32'h0; m_cnt = 0; m_halted = 0; m_latch = '0;
    end else if (rd) begin
      m_pc = tgt - (tgt % 4); m_latch = '0; m_halted = 0;
    end else if (st) begin
      m_latch = m_latch;
    end else if (m_halted) begin
      m_latch = '0;
    end else begin
      inst    = mem[(m_pc / 4) % WORDS];
      m_latch = {1'b1, inst, m_pc, m_pc + 32'd4, m_cnt};
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 1;
      if (inst == HALT) m_halted = 1;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
    reset           = rst;
    from_DE_to_FE   = st;
    from_AGEX_to_FE = {rd, tgt};
    model_edge(rst, st, rd, tgt);
    @(posedge clk);
    #1;
    chk("latch", FE_latch_out, m_latch);
    chk("halted", LW'(halted), LW'(m_halted));
    chk("imem_addr", LW'(imem_addr), LW'((m_pc / 4) % WORDS));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    for (int unsigned i = 0; i < WORDS; i++) mem[i] = ADDI;
    reset = 1'b1; from_DE_to_FE = 1'b0; from_AGEX_to_FE = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_latch", FE_latch_out, '0);
    chk("rst_halted", LW'(halted), '0);

    // Straight-line fetch
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("sl_valid", LW'(FE_latch_out[128]), LW'(1));
      chk("sl_inst", LW'(FE_latch_out[127:96]), LW'(ADDI));
      chk("sl_pc", LW'(FE_latch_out[95:64]), LW'(4 * i));
      chk("sl_pcplus", LW'(FE_latch_out[63:32]), LW'(4 * i + 4));
      chk("sl_cnt", LW'(FE_latch_out[31:0]), LW'(i));
    end

    // Stall holds everything
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_pc", LW'(FE_latch_out[95:64]), LW'(8));
      chk("stall_addr", LW'(imem_addr), LW'(3));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_stall_pc", LW'(FE_latch_out[95:64]), LW'(12));
    chk("post_stall_cnt", LW'(FE_latch_out[31:0]), LW'(3));

    // Redirect beats a simultaneous stall
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("redir_bubble", FE_latch_out, '0);
    chk("redir_addr", LW'(imem_addr), LW'(32'h40));
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_pc", LW'(FE_latch_out[95:64]), LW'(32'h100));
    chk("redir_cnt", LW'(FE_latch_out[31:0]), LW'(4));

    // Halt at 0x20, then resume via redirect
    mem[8] = HALT;
    step(1'b0, 1'b0, 1'b1, 32'h18);
    run(3);
    chk("halt_inst", LW'(FE_latch_out[127:96]), LW'(HALT));
    chk("halt_valid", LW'(FE_latch_out[128]), LW'(1));
    chk("halt_flag", LW'(halted), LW'(1));
    run(2);
    chk("halt_bubble", FE_latch_out, '0);
    chk("halt_addr", LW'(imem_addr), LW'(9));
    step(1'b0, 1'b0, 1'b1, 32'h40);
    chk("unhalt", LW'(halted), '0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("resume_pc", LW'(FE_latch_out[95:64]), LW'(32'h40));

    // PC wrap and misaligned target
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", LW'(FE_latch_out[95:64]), LW'(32'hFFFF_FFFC));
    chk("wrap_pcplus", LW'(FE_latch_out[63:32]), '0);
    chk("wrap_addr", LW'(imem_addr), '0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0102);
    chk("misal_addr", LW'(imem_addr), LW'(32'h40));
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("misal_pc", LW'(FE_latch_out[95:64]), LW'(32'h100));

    // Reset while halted and stalled
    step(1'b0, 1'b0, 1'b1, 32'h20);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_halt", LW'(halted), LW'(1));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mid_rst_latch", FE_latch_out, '0);
    chk("mid_rst_halted", LW'(halted), '0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_pc", LW'(FE_latch_out[95:64]), '0);
    chk("mid_rst_cnt", LW'(FE_latch_out[31:0]), '0);

    // Random mix against the model
    for (int unsigned i = 0; i < WORDS; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
    for (int unsigned i = 0; i < 600; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? $urandom
                                        : ((32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3)));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fe_fetch_stage.md
Name: fe_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32 pipeline, and the producer side of the FE latch that the decode stage consumes. It owns the PC register, drives the instruction-memory read address, and packs {valid, inst, PC, pcplus, inst_count} into the FE latch. It honours the decode-stage stall, applies AGEX branch-mispredict redirects with bubble insertion, and enters a sticky halt on a halt instruction.

Parameters:
DBITS, 32, data/PC width
INSTBITS, 32, instruction width
STARTPC, 32'h0000_0000, PC value after reset
IMEM_ADDRBITS, 14, word-address width of instruction memory
HALT_INST, 32'h0000_0073, encoding that triggers sticky halt (ECALL)
FE_LATCH_WIDTH, 1+INSTBITS+3*DBITS (=129), FE latch width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
from_DE_to_FE  in  1  decode stall (stall_DE)
from_AGEX_to_FE  in  DBITS+1  {br_redirect (MSB), br_target[DBITS-1:0]}
imem_addr  out  IMEM_ADDRBITS  word address = PC_FE[IMEM_ADDRBITS+1:2]
imem_rdata  in  INSTBITS  instruction word, combinational same-cycle read
FE_latch_out  out  FE_LATCH_WIDTH  {valid, inst, PC, pcplus, inst_count}, MSB→LSB, packed in this order
halted  out  1  sticky-halt flag

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and overrides everything. On reset: PC_FE=STARTPC, inst_count_FE=0, FE latch all-zero (valid=0), halted=0.
- Combinational: pcplus_FE = PC_FE+4, wrapping mod 2^DBITS. imem_addr = PC_FE[IMEM_ADDRBITS+1:2]; upper PC bits are ignored, so addresses alias. PC[1:0] are always 0 because all targets are word-aligned; a non-aligned br_target has its low two bits forced to 0.
- fetch_ok = !halted && !stall_DE && !br_redirect.
- Priority per cycle (highest first):
  1) reset;
  2) br_redirect=1: PC_FE<=br_target, FE latch<=all-zero bubble, halted<=0, inst_count unchanged. Redirect wins over a simultaneous stall_DE.
  3) stall_DE=1: PC_FE, inst_count_FE and FE latch all hold their values.
  4) halted=1: PC_FE holds, FE latch<=all-zero (valid=0).
  5) normal (fetch_ok): FE latch<={1, imem_rdata, PC_FE, pcplus_FE, inst_count_FE}, PC_FE<=pcplus_FE, inst_count_FE<=inst_count_FE+1 (wraps at 2^DBITS).
- Halt: in the normal case, if imem_rdata==HALT_INST, the instruction is latched with valid=1 and halted<=1 in the same edge. Thereafter only bubbles are emitted until a redirect (halt on a wrong path is cancelled) or reset.
- inst_count is a monotonic fetch tag. It is not rolled back on redirect, so squashed fetches consume tags.
- Latency: an instruction at PC X appears in FE_latch_out one cycle after PC_FE==X, with no stall. The first valid latch appears on the first edge after reset deasserts, and carries PC=STARTPC and inst_count=0.
- A redirect takes 1 cycle: the edge that sees br_redirect latches a bubble, and the target instruction is latched on the next edge if fetch_ok.
- FE_latch_out is a direct register output with no combinational path from inputs. The halted output is also registered.

Test Plan:
- Reset then straight-line: imem returns 0x00100093 at every address, no stall → latches carry PC 0,4,8 and pcplus 4,8,12, inst_count 0,1,2, valid=1 each cycle.
- Stall: assert stall_DE for 3 cycles while the latch holds PC=8 → latch and PC_FE frozen for 3 cycles; next latch PC=12, inst_count=3.
- Redirect with simultaneous stall: stall_DE=1 and {1, 0x0000_0100} at PC_FE=0x10 → latch becomes all-zero, PC_FE=0x100, inst_count unchanged; next latch PC=0x100 valid=1.
- Halt: imem returns 0x00000073 at PC 0x20 → latched valid with inst 0x73, halted=1, then bubbles with PC_FE=0x24 frozen. A redirect to 0x40 clears halted and fetch resumes at 0x40.
- Wrap: redirect to 0xFFFF_FFFC → latch PC=0xFFFF_FFFC, pcplus=0x0000_0000, next PC 0. A misaligned target 0x0000_0102 is fetched as 0x100.
- Reset mid-stall/halt: assert reset while halted=1 and stall_DE=1 → next edge gives PC=STARTPC, latch zero, halted=0, inst_count=0.
